// File: rtl/edge_counter_pkg.sv
// Shared types and record layout for the multi-channel edge counter.
package edge_counter_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_START = 2'b01,
        OP_STOP  = 2'b10,
        OP_CLEAR = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        EDGE_RISE     = 2'b00,
        EDGE_FALL     = 2'b01,
        EDGE_BOTH     = 2'b10,
        EDGE_RISE_ALT = 2'b11
    } edge_mode_e;

    localparam int unsigned CH_IDX_W = 4;

    localparam int unsigned CMD_OP_LSB   = 62;
    localparam int unsigned CMD_MODE_LSB = 60;

    localparam int unsigned REC_TIME_LSB = 64;
    localparam int unsigned REC_CH_LSB   = 56;
    localparam int unsigned REC_SAT_BIT  = 55;
    localparam int unsigned REC_CNT_LSB  = 0;

endpackage

// File: rtl/edge_channel.sv
// One edge-counting channel: synchroniser, edge detect, saturating counter,
// IDLE/COUNT state, pending snapshot and sticky drop flag.
module edge_channel
    import edge_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 grant,
    input  edge_mode_e           mode_in,
    input  logic [63:0]          counter,
    output logic                 pend,
    output logic [CNT_WIDTH-1:0] snap_count,
    output logic                 snap_sat,
    output logic [63:0]          snap_time,
    output logic                 drop_err
);

    typedef enum logic {ST_IDLE, ST_COUNT} ch_state_e;

    ch_state_e             state, state_next;
    edge_mode_e            mode;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  sig_prev;
    logic                  rise, fall, edge_hit;
    logic [CNT_WIDTH-1:0]  count, cnt_next;
    logic                  sat, sat_next;
    logic                  counting, pend_eff, take_snap, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            sig_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig};
            sig_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~sig_prev;
    assign fall     = ~sync_q[SYNC_STAGES-1] & sig_prev;
    assign counting = (state == ST_COUNT);

    always_comb begin
        edge_hit = rise;
        case (mode)
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = rise;
        endcase
    end

    // Next count feeds both the counter and the snapshot, so an edge in the STOP cycle is captured
    always_comb begin
        cnt_next = count;
        sat_next = sat;
        if (counting && edge_hit && !(&count)) begin
            cnt_next = count + 1'b1;
            if (&cnt_next) sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear)                 state_next = ST_IDLE;
        else if (start)            state_next = ST_COUNT;
        else if (stop && counting) state_next = ST_IDLE;
    end

    // A grant in the same cycle frees the slot before a STOP re-fills it
    assign pend_eff  = pend & ~grant;
    assign take_snap = stop && counting && !pend_eff;
    assign drop      = stop && counting && pend_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= EDGE_RISE;
            count      <= '0;
            sat        <= 1'b0;
            pend       <= 1'b0;
            snap_count <= '0;
            snap_sat   <= 1'b0;
            snap_time  <= '0;
            drop_err   <= 1'b0;
        end else begin
            if (start) begin
                count <= '0;
                sat   <= 1'b0;
                mode  <= mode_in;
            end else if (clear) begin
                count <= '0;
            end else begin
                count <= cnt_next;
                sat   <= sat_next;
            end

            if (clear)          pend <= 1'b0;
            else if (take_snap) pend <= 1'b1;
            else if (grant)     pend <= 1'b0;

            if (take_snap) begin
                snap_count <= cnt_next;
                snap_sat   <= sat_next;
                snap_time  <= counter;
            end

            if (clear)     drop_err <= 1'b0;
            else if (drop) drop_err <= 1'b1;
        end
    end

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter: command decode, round-robin record arbiter
// and registered FIFO write port.
module multi_edge_counter
    import edge_counter_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [NUM_CH-1:0] input_sig,
    input  logic [63:0]       cmd_in,
    input  logic              cmd_valid,
    input  logic [63:0]       counter,
    input  logic              fifo_full,
    output logic              write,
    output logic [127:0]      count_out,
    output logic [NUM_CH-1:0] drop_err
);

    opcode_e              op;
    edge_mode_e           mode;
    logic [NUM_CH-1:0]    mask, start_v, stop_v, clear_v;
    logic [NUM_CH-1:0]    pend, snap_sat, grant;
    logic [CNT_WIDTH-1:0] snap_count [NUM_CH];
    logic [63:0]          snap_time  [NUM_CH];
    logic [CH_IDX_W-1:0]  rr_ptr, grant_idx;
    logic                 grant_valid;
    logic [127:0]         rec;
    logic                 unused_cmd;

    assign op         = opcode_e'(cmd_in[CMD_OP_LSB +: 2]);
    assign mode       = edge_mode_e'(cmd_in[CMD_MODE_LSB +: 2]);
    assign mask       = cmd_in[NUM_CH-1:0];
    assign unused_cmd = ^cmd_in[59:NUM_CH];

    assign start_v = (cmd_valid && op == OP_START) ? mask : '0;
    assign stop_v  = (cmd_valid && op == OP_STOP)  ? mask : '0;
    assign clear_v = (cmd_valid && op == OP_CLEAR) ? mask : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk        (s_axi_aclk),
            .rst_n      (s_axi_aresetn),
            .sig        (input_sig[i]),
            .start      (start_v[i]),
            .stop       (stop_v[i]),
            .clear      (clear_v[i]),
            .grant      (grant[i]),
            .mode_in    (mode),
            .counter    (counter),
            .pend       (pend[i]),
            .snap_count (snap_count[i]),
            .snap_sat   (snap_sat[i]),
            .snap_time  (snap_time[i]),
            .drop_err   (drop_err[i])
        );
    end

    // Rotating priority as two ordered passes: indices at/after rr_ptr first, then wrap
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (!fifo_full && !write) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!grant_valid && pend[i] && CH_IDX_W'(i) >= rr_ptr) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_IDX_W'(i);
                    grant[i]    = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!grant_valid && pend[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_IDX_W'(i);
                    grant[i]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rec = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                rec[REC_TIME_LSB +: 64]       = snap_time[i];
                rec[REC_CH_LSB +: CH_IDX_W]   = CH_IDX_W'(i);
                rec[REC_SAT_BIT]              = snap_sat[i];
                rec[REC_CNT_LSB +: CNT_WIDTH] = snap_count[i];
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            write     <= 1'b0;
            count_out <= '0;
            rr_ptr    <= '0;
        end else begin
            write <= grant_valid;
            if (grant_valid) begin
                count_out <= rec;
                rr_ptr    <= (grant_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Directed self-checking bench for multi_edge_counter (default build plus a
// 1-channel, 4-bit-count build for saturation).
module tb_multi_edge_counter;
    import edge_counter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   input_sig;
    logic [63:0]  cmd_in;
    logic         cmd_valid;
    logic [63:0]  counter;
    logic         fifo_full;
    logic         write;
    logic [127:0] count_out;
    logic [3:0]   drop_err;

    logic         sig_s;
    logic         cmd_valid_s;
    logic         fifo_full_s;
    logic         write_s;
    logic [127:0] count_out_s;
    logic         drop_err_s;

    int           n_checks = 0;
    int           n_fail   = 0;
    int unsigned  cyc      = 0;
    logic [127:0] rec_q [$];
    int unsigned  cyc_q [$];
    logic [127:0] rec_s [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_edge_counter #(.NUM_CH(4), .CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .input_sig     (input_sig),
        .cmd_in        (cmd_in),
        .cmd_valid     (cmd_valid),
        .counter       (counter),
        .fifo_full     (fifo_full),
        .write         (write),
        .count_out     (count_out),
        .drop_err      (drop_err)
    );

    multi_edge_counter #(.NUM_CH(1), .CNT_WIDTH(4), .SYNC_STAGES(2)) dut_sat (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .input_sig     (sig_s),
        .cmd_in        (cmd_in),
        .cmd_valid     (cmd_valid_s),
        .counter       (counter),
        .fifo_full     (fifo_full_s),
        .write         (write_s),
        .count_out     (count_out_s),
        .drop_err      (drop_err_s)
    );

    always @(negedge clk) begin
        if (rst_n && write) begin
            rec_q.push_back(count_out);
            cyc_q.push_back(cyc);
        end
        if (rst_n && write_s) rec_s.push_back(count_out_s);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_rec(input logic [63:0] t, input logic [3:0] ch,
                                            input logic sat, input logic [31:0] cnt);
        mk_rec = {t, 4'h0, ch, sat, 23'h0, cnt};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [1:0] md, input logic [15:0] mask);
        cmd_in    = {op, md, 44'h0, mask};
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        cmd_in    = '0;
    endtask

    task automatic cmd_s(input logic [1:0] op, input logic [1:0] md);
        cmd_in      = {op, md, 44'h0, 16'h0001};
        cmd_valid_s = 1'b1;
        tick(1);
        cmd_valid_s = 1'b0;
        cmd_in      = '0;
    endtask

    task automatic pulse(input int ch, input int n);
        repeat (n) begin
            input_sig[ch] = 1'b1;
            tick(2);
            input_sig[ch] = 1'b0;
            tick(2);
        end
    endtask

    task automatic take(input string tag, input logic [127:0] exp, output int unsigned wc);
        logic [127:0] r;
        r  = 'x;
        wc = 0;
        if (rec_q.size() > 0) begin
            r  = rec_q.pop_front();
            wc = cyc_q.pop_front();
        end
        check_eq(tag, r, exp);
    endtask

    task automatic take_s(input string tag, input logic [127:0] exp);
        logic [127:0] r;
        r = 'x;
        if (rec_s.size() > 0) r = rec_s.pop_front();
        check_eq(tag, r, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned stop_c, wc, prev;

        rst_n       = 1'b0;
        input_sig   = '0;
        cmd_in      = '0;
        cmd_valid   = 1'b0;
        counter     = '0;
        fifo_full   = 1'b0;
        sig_s       = 1'b0;
        cmd_valid_s = 1'b0;
        fifo_full_s = 1'b0;
        tick(3);
        check_eq("rst_write",    128'(write),     128'd0);
        check_eq("rst_count_out", count_out,      128'd0);
        check_eq("rst_drop_err", 128'(drop_err),  128'd0);
        rst_n = 1'b1;
        tick(2);

        // Rising edges on ch0, plus STOP-to-write latency
        cmd(2'b01, 2'b00, 16'h0001);
        pulse(0, 5);
        tick(5);
        counter = 64'h1000;
        cmd(2'b10, 2'b00, 16'h0001);
        stop_c = cyc - 1;
        tick(6);
        check_eq("t1_nrec", 128'(rec_q.size()), 128'd1);
        take("t1_rec", mk_rec(64'h1000, 4'd0, 1'b0, 32'd5), wc);
        check_eq("t1_latency", 128'(wc - stop_c), 128'd2);

        // Both-edge mode on ch2: 3 pulses = 6 edges
        cmd(2'b01, 2'b10, 16'h0004);
        pulse(2, 3);
        tick(5);
        counter = 64'h2000;
        cmd(2'b10, 2'b00, 16'h0004);
        tick(4);
        take("t2_both_ch2", mk_rec(64'h2000, 4'd2, 1'b0, 32'd6), wc);

        // Falling mode on ch1: held high before START, dropped once
        input_sig[1] = 1'b1;
        tick(6);
        cmd(2'b01, 2'b01, 16'h0002);
        input_sig[1] = 1'b0;
        tick(6);
        counter = 64'h2100;
        cmd(2'b10, 2'b00, 16'h0002);
        tick(4);
        take("t2_fall_ch1", mk_rec(64'h2100, 4'd1, 1'b0, 32'd1), wc);

        // Saturation with a 4-bit count; restart clears the flag
        cmd_s(2'b01, 2'b00);
        repeat (20) begin
            sig_s = 1'b1;
            tick(2);
            sig_s = 1'b0;
            tick(2);
        end
        tick(5);
        counter = 64'h3000;
        cmd_s(2'b10, 2'b00);
        tick(4);
        take_s("t3_sat", mk_rec(64'h3000, 4'd0, 1'b1, 32'hF));
        cmd_s(2'b01, 2'b00);
        tick(2);
        counter = 64'h3100;
        cmd_s(2'b10, 2'b00);
        tick(4);
        take_s("t3_sat_cleared", mk_rec(64'h3100, 4'd0, 1'b0, 32'd0));

        // Back-pressure on all four channels, then ordered drain
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        cmd(2'b01, 2'b00, 16'h000F);
        pulse(3, 2);
        tick(5);
        fifo_full = 1'b1;
        counter   = 64'h4000;
        cmd(2'b10, 2'b00, 16'h000F);
        tick(10);
        check_eq("t4_full_hold", 128'(rec_q.size()), 128'd0);
        fifo_full = 1'b0;
        tick(12);
        check_eq("t4_nrec", 128'(rec_q.size()), 128'd4);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            take($sformatf("t4_rec%0d", i),
                 mk_rec(64'h4000, 4'(i), 1'b0, (i == 3) ? 32'd2 : 32'd0), wc);
            if (i > 0) check_eq($sformatf("t4_gap%0d", i), 128'(wc - prev), 128'd2);
            prev = wc;
        end

        // Second STOP while the first record is still pending
        fifo_full = 1'b1;
        cmd(2'b01, 2'b00, 16'h0001);
        pulse(0, 3);
        tick(5);
        counter = 64'h5000;
        cmd(2'b10, 2'b00, 16'h0001);
        cmd(2'b01, 2'b00, 16'h0001);
        pulse(0, 1);
        tick(5);
        counter = 64'h5100;
        cmd(2'b10, 2'b00, 16'h0001);
        check_eq("t5_drop_set", 128'(drop_err), 128'h1);
        fifo_full = 1'b0;
        tick(6);
        check_eq("t5_nrec", 128'(rec_q.size()), 128'd1);
        take("t5_rec", mk_rec(64'h5000, 4'd0, 1'b0, 32'd3), wc);
        cmd(2'b11, 2'b00, 16'h0001);
        check_eq("t5_drop_clr", 128'(drop_err), 128'h0);

        // Reset with two records pending and one write in flight
        fifo_full = 1'b1;
        counter   = 64'h6000;
        cmd(2'b01, 2'b00, 16'h0003);
        cmd(2'b10, 2'b00, 16'h0003);
        cmd(2'b01, 2'b00, 16'h0001);
        cmd(2'b10, 2'b00, 16'h0001);
        check_eq("t6_drop_pre", 128'(drop_err), 128'h1);
        fifo_full = 1'b0;
        tick(1);
        check_eq("t6_write_pre", 128'(write), 128'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_write",    128'(write),    128'd0);
        check_eq("t6_rst_count_out", count_out,     128'd0);
        check_eq("t6_rst_drop_err", 128'(drop_err), 128'd0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check_eq("t6_no_stale", 128'(rec_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_counter.md
# multi_edge_counter

Parametrised, multi-channel successor to the single-channel edge-counter controller. Counts edges on `NUM_CH` asynchronous inputs with a per-command edge mode and channel mask. On STOP it snapshots each channel's count and the 64-bit timeline counter, then emits 128-bit records into the RTI input FIFO through a round-robin arbiter that respects FIFO back-pressure. It sits between the GPO core (command source) and the RTI core (record sink) in the edge-counter AXI peripheral.

## Interface

Parameters:
- `NUM_CH`, default 4, number of input channels (1..16).
- `CNT_WIDTH`, default 16, per-channel count width (1..32).
- `SYNC_STAGES`, default 2, input synchroniser depth (≥2).

Ports:
- `s_axi_aclk`  in  1  sole clock.
- `s_axi_aresetn`  in  1  asynchronous, active-low reset.
- `input_sig`  in  NUM_CH  asynchronous edge inputs.
- `cmd_in`  in  64  command word (GPO output [63:0]).
- `cmd_valid`  in  1  one-cycle command strobe (GPO `selected`).
- `counter`  in  64  timeline counter.
- `fifo_full`  in  1  RTI FIFO full.
- `write`  out  1  one-cycle record push.
- `count_out`  out  128  record data, valid while `write`=1.
- `drop_err`  out  NUM_CH  sticky per-channel record-dropped flag.

## Operation

Command fields:
- `cmd_in[63:62]` opcode: 00 NOP, 01 START, 10 STOP, 11 CLEAR.
- `cmd_in[61:60]` edge mode: 00 rising, 01 falling, 10 both, 11 treated as rising.
- `cmd_in[NUM_CH-1:0]` channel mask. A command acts only on masked channels; other bits are ignored.

Per-channel state is IDLE or COUNT, plus an independent `pend` flag with snapshot registers.
- START: state becomes COUNT, count cleared to 0, edge mode latched. Applies from IDLE or COUNT (restart). `pend` and its snapshot are preserved.
- STOP in COUNT with `pend`=0: snapshot count, saturation flag and `counter`; set `pend`; state becomes IDLE.
- STOP in COUNT with `pend`=1: state becomes IDLE, snapshot is untouched, `drop_err` bit is set.
- STOP in IDLE: no effect.
- CLEAR: state becomes IDLE, count 0, `pend` 0, `drop_err` bit 0.
- Count saturates at all-ones and sets the channel's saturation flag, which is cleared by START.
- Edge in the same cycle as STOP: included in the snapshot. Edge in the same cycle as START: not counted.

Record layout:
- [127:64] snapshot of `counter`.
- [63:60] zero.
- [59:56] channel index.
- [55] saturation flag.
- [54:32] zero.
- [31:0] count, zero-extended.

Arbiter:
- Round-robin over channels with `pend`=1, starting after the last granted index (index 0 after reset).
- Grants only when `fifo_full`=0 and `write`=0.
- The granted channel's `pend` clears in the grant cycle.

## Timing

- Reset values: `write`=0, `count_out`=0, `drop_err`=0; all channels IDLE, counts 0, `pend` 0, round-robin pointer 0.
- Input edge to count increment: SYNC_STAGES+1 cycles after the input transition is sampled.
- Commands act in the cycle `cmd_valid`=1; the updated state is visible the next cycle.
- STOP cycle N sets `pend` at N+1. The earliest grant is at N+1, with `write`/`count_out` registered high at N+2.
- `write` is a single-cycle pulse. Throughput is at most one record every 2 cycles.
- `fifo_full` is sampled in the grant cycle only. A record is never issued while `fifo_full`=1.
- STOP while a grant of the same channel is in progress: the grant clears `pend` first, and the STOP sets it anew with no drop.
- CLEAR in the same cycle as a grant of that channel: the grant wins and the record is emitted.
- Reset asserted mid-operation returns all state to reset values immediately. Any in-flight record is lost and `write` drops asynchronously.

## Structure

- Package `edge_counter_pkg` holds:
  - the opcode enum and the edge-mode enum;
  - record field bit positions;
  - the `CH_IDX_W` constant (4).
- Sub-module `edge_channel` contains the synchroniser, edge detect, saturating counter, IDLE/COUNT state, `pend`, snapshot and `drop_err` for one channel. It is instantiated NUM_CH times in a generate loop.
- Top level `multi_edge_counter` contains command decode, the round-robin arbiter and the output register.

## Test plan

- START mask 0x1, rising mode; 5 pulses on ch0; STOP at `counter`=0x1000 → one write with [127:64]=0x1000, [59:56]=0, [31:0]=5.
- Both-edge mode on ch2 with 3 pulses (6 edges), STOP → count 6; falling mode on ch1 with the input held high then dropped once → count 1.
- CNT_WIDTH=4, 20 rising edges → count 0xF with [55]=1; a subsequent START clears [55].
- STOP on all 4 channels with `fifo_full`=1 for 10 cycles → no write. After release → 4 writes in order ch0..3, spaced 2 cycles apart.
- STOP on ch0 twice with a START between and `fifo_full` held high → `drop_err[0]`=1, one record with the first count. CLEAR → `drop_err[0]`=0.
- Deassert `s_axi_aresetn` while 2 records are pending → `write`=0 and all outputs 0. After release, no stale record is emitted.
